// File: rtl/pooling_layer.sv
// pooling_layer: streaming FILTER_SIZE x FILTER_SIZE max-pooling, stride STRIDE, raster-order pixels.
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset (counters, window, outputs)
//   clk_en      : pixel strobe, state advances only when high
//   input_data  : CHANNELS packed unsigned D_WIDTH samples, channel c at [c*D_WIDTH +: D_WIDTH]
//   output_data : pooled pixel, same packing, held between pulses
//   valid       : one-cycle pulse marking a new pooled pixel
module pooling_layer #(
    parameter int D_WIDTH     = 8,
    parameter int CHANNELS    = 3,
    parameter int FILTER_SIZE = 2,
    parameter int IMAGE_SIZE  = 64,
    parameter int STRIDE      = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_en,
    input  logic [CHANNELS*D_WIDTH-1:0] input_data,
    output logic [CHANNELS*D_WIDTH-1:0] output_data,
    output logic                        valid
);
    localparam int PW = CHANNELS * D_WIDTH;
    localparam int F  = FILTER_SIZE;
    localparam int LB = (F > 1) ? F - 1 : 1;
    localparam int CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int RW = (F > 1) ? $clog2(F) : 1;
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [SW-1:0] r_cph;
    logic [SW-1:0] r_rph;
    logic [PW-1:0] r_win [F][F];
    logic [PW-1:0] r_lb [LB][IMAGE_SIZE];
    logic [PW-1:0] r_out;
    logic          r_valid;
    logic [PW-1:0] w_colv [F];
    logic [PW-1:0] w_max;
    logic          w_last_col;
    logic          w_ready;

    // Incoming column: index k is the pixel k rows above the current one at this column.
    always_comb begin
        w_colv[0] = input_data;
        for (int k = 1; k < F; k++)
            w_colv[k] = r_lb[k-1][r_col];
    end

    // Max over the new column plus the F-1 newest stored columns, i.e. the window after the shift.
    always_comb begin
        w_max = '0;
        for (int c = 0; c < CHANNELS; c++)
            for (int i = 0; i < F; i++) begin
                w_max[c*D_WIDTH +: D_WIDTH] = (w_colv[i][c*D_WIDTH +: D_WIDTH] > w_max[c*D_WIDTH +: D_WIDTH])
                                            ? w_colv[i][c*D_WIDTH +: D_WIDTH] : w_max[c*D_WIDTH +: D_WIDTH];
                for (int j = 0; j < F - 1; j++)
                    w_max[c*D_WIDTH +: D_WIDTH] = (r_win[i][j][c*D_WIDTH +: D_WIDTH] > w_max[c*D_WIDTH +: D_WIDTH])
                                                ? r_win[i][j][c*D_WIDTH +: D_WIDTH] : w_max[c*D_WIDTH +: D_WIDTH];
            end
    end

    assign w_last_col = (r_col == CW'(IMAGE_SIZE - 1));
    // Phase counters hold (c-(F-1)) mod S and (r-(F-1)) mod S once the window fits.
    assign w_ready    = (r_row == RW'(F - 1)) && (r_col >= CW'(F - 1)) && (r_cph == '0) && (r_rph == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col   <= '0;
            r_row   <= '0;
            r_cph   <= '0;
            r_rph   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < F; i++)
                for (int j = 0; j < F; j++)
                    r_win[i][j] <= '0;
        end else begin
            r_valid <= clk_en && w_ready;
            if (clk_en) begin
                r_col <= w_last_col ? '0 : r_col + 1'b1;
                if (w_last_col) begin
                    r_cph <= '0;
                    r_row <= (r_row == RW'(F - 1)) ? r_row : r_row + 1'b1;
                    if (r_row == RW'(F - 1))
                        r_rph <= (r_rph == SW'(STRIDE - 1)) ? '0 : r_rph + 1'b1;
                end else if (r_col >= CW'(F - 1)) begin
                    r_cph <= (r_cph == SW'(STRIDE - 1)) ? '0 : r_cph + 1'b1;
                end
                if (w_ready)
                    r_out <= w_max;
                for (int i = 0; i < F; i++) begin
                    r_win[i][0] <= w_colv[i];
                    for (int j = 1; j < F; j++)
                        r_win[i][j] <= r_win[i][j-1];
                end
            end
        end
    end

    // Line buffers are indexed by column, so no reset is needed: rows below F-1 are never pooled.
    always_ff @(posedge clk) begin
        if (clk_en)
            for (int k = 0; k < F - 1; k++)
                r_lb[k][r_col] <= w_colv[k];
    end

    assign output_data = r_out;
    assign valid       = r_valid;
endmodule

// File: tb/tb_pooling_layer.sv
module tb_pooling_layer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b0;
    logic [23:0] input_data = '0;
    logic [23:0] output_data;
    logic        valid;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    bit mon_on = 1'b0;
    logic en_at_edge;

    typedef struct {
        logic [23:0] tl, tr, bl, br, exp;
    } vec_t;
    vec_t vecs [5];

    pooling_layer dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .input_data(input_data), .output_data(output_data), .valid(valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ramp(input int r, input int c);
        return 8'((r * 64 + c) & 255);
    endfunction

    function automatic logic [23:0] exp_ramp(input int idx);
        int r, c;
        logic [7:0] m;
        r = (idx / 32) * 2;
        c = (idx % 32) * 2;
        m = 8'h00;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if (ramp(r + dr, c + dc) > m) m = ramp(r + dr, c + dc);
        return {m, m, m};
    endfunction

    // Ramp monitor: every pulse compared in order; no pulse allowed after a disabled edge.
    always @(posedge clk) begin
        en_at_edge = clk_en;
        #1;
        if (mon_on) begin
            if (valid) begin
                checks++;
                if (vcnt >= 512) begin
                    errors++;
                    $display("FAIL ramp_extra: pulse %0d, at most 512 allowed", vcnt);
                end else if (output_data !== exp_ramp(vcnt)) begin
                    errors++;
                    $display("FAIL ramp_data[%0d]: got %h want %h", vcnt, output_data, exp_ramp(vcnt));
                end
                vcnt++;
            end
            if (!en_at_edge) begin
                checks++;
                if (valid !== 1'b0) begin
                    errors++;
                    $display("FAIL valid_after_idle: got %b want 0", valid);
                end
            end
        end
    end

    task automatic push(input logic [23:0] d, input logic en);
        @(negedge clk);
        input_data = d;
        clk_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clk_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic stream_ramp(input bit toggle);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 64; c++) begin
                push({3{ramp(r, c)}}, 1'b1);
                if (toggle) push(24'hFFFFFF, 1'b0);
            end
        push(24'h0, 1'b0);
        push(24'h0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{tl: 24'h0000FF, tr: 24'h00FF00, bl: 24'hFF0000, br: 24'h000000, exp: 24'hFFFFFF};
        vecs[1] = '{tl: 24'h808080, tr: 24'h7F7F7F, bl: 24'h010101, br: 24'h000000, exp: 24'h808080};
        vecs[2] = '{tl: 24'h102030, tr: 24'h0A0B0C, bl: 24'h01FF02, br: 24'h7F0080, exp: 24'h7FFF80};
        vecs[3] = '{tl: 24'h555555, tr: 24'h555555, bl: 24'h555555, br: 24'h555555, exp: 24'h555555};
        vecs[4] = '{tl: 24'h000001, tr: 24'h000100, bl: 24'h010000, br: 24'h020202, exp: 24'h020202};

        #12;
        check("reset_valid", {23'h0, valid}, 24'h0);
        check("reset_data", output_data, 24'h0);
        reset = 1'b0;

        // Table vectors: a single window at the top-left corner, everything else zero.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int c = 0; c < 64; c++) push(c == 0 ? vecs[v].tl : c == 1 ? vecs[v].tr : 24'h0, 1'b1);
            push(vecs[v].bl, 1'b1);
            check($sformatf("vec%0d_early_valid", v), {23'h0, valid}, 24'h0);
            push(vecs[v].br, 1'b1);
            check($sformatf("vec%0d_valid", v), {23'h0, valid}, 24'h1);
            check($sformatf("vec%0d_data", v), output_data, vecs[v].exp);
            push(24'hABCDEF, 1'b1);
            check($sformatf("vec%0d_drop", v), {23'h0, valid}, 24'h0);
            check($sformatf("vec%0d_hold", v), output_data, vecs[v].exp);
        end

        // Continuous ramp, then the same ramp with clk_en toggling.
        for (int t = 0; t < 2; t++) begin
            do_reset();
            vcnt = 0;
            mon_on = 1'b1;
            stream_ramp(t[0]);
            mon_on = 1'b0;
            check($sformatf("ramp%0d_count", t), 24'(vcnt), 24'd512);
        end

        // Row 0 alone must produce nothing.
        do_reset();
        vcnt = 0;
        mon_on = 1'b1;
        for (int c = 0; c < 64; c++) push({3{ramp(0, c)}}, 1'b1);
        push(24'h0, 1'b0);
        mon_on = 1'b0;
        check("row0_count", 24'(vcnt), 24'd0);

        // Asynchronous reset in the middle of row 5, then a fresh image.
        do_reset();
        for (int i = 0; i < 5 * 64 + 30; i++) push({3{ramp(i / 64, i % 64)}}, 1'b1);
        check("pre_reset_data", output_data, {3{ramp(5, 29)}});
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_valid", {23'h0, valid}, 24'h0);
        check("async_reset_data", output_data, 24'h0);
        clk_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        vcnt = 0;
        mon_on = 1'b1;
        stream_ramp(1'b0);
        mon_on = 1'b0;
        check("post_reset_count", 24'(vcnt), 24'd512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
